// File: rtl/idli_pkg.sv
// Shared types and the instruction decode function for the idli core.
package idli_pkg;

   typedef enum logic {
      PIPE_ALU   = 1'b0,
      PIPE_SHIFT = 1'b1
   } pipe_t;

   typedef enum logic [1:0] {
      ALU_OP_ADD = 2'd0,
      ALU_OP_AND = 2'd1,
      ALU_OP_OR  = 2'd2,
      ALU_OP_XOR = 2'd3
   } alu_op_t;

   typedef enum logic [2:0] {
      CMP_OP_EQ  = 3'd0,
      CMP_OP_NE  = 3'd1,
      CMP_OP_LT  = 3'd2,
      CMP_OP_GE  = 3'd3,
      CMP_OP_LTU = 3'd4,
      CMP_OP_GEU = 3'd5,
      CMP_OP_BC  = 3'd6,
      CMP_OP_BS  = 3'd7
   } cmp_op_t;

   typedef enum logic [1:0] {
      SHIFT_OP_ROL = 2'd0,
      SHIFT_OP_ROR = 2'd1,
      SHIFT_OP_SHL = 2'd2,
      SHIFT_OP_SHR = 2'd3
   } shift_op_t;

   typedef struct packed {
      pipe_t     pipe;
      alu_op_t   alu_op;
      logic      alu_inv;
      logic      alu_cin;
      cmp_op_t   cmp_op;
      shift_op_t shift_op;
   } decode_t;

   // Decode a 16b encoding into execution control signals.
   function automatic decode_t idli_decode_f(input logic [15:0] enc);
      decode_t    dec;
      logic [3:0] n0;
      logic [3:0] n1;
      logic [3:0] n3;
      n0 = enc[3:0];
      n1 = enc[7:4];
      n3 = enc[15:12];

      dec.pipe = (n0 == 4'hA && n3[3]) ? PIPE_SHIFT : PIPE_ALU;

      if (n0 == 4'h2 || n0 == 4'h3 || (n0 == 4'hB && n1[2:0] == 3'b110)) begin
         dec.alu_op = ALU_OP_AND;
      end else if (n0 == 4'h4) begin
         dec.alu_op = ALU_OP_OR;
      end else if (n0 == 4'h5 || (n0 == 4'hA && n3 == 4'hE)) begin
         dec.alu_op = ALU_OP_XOR;
      end else begin
         dec.alu_op = ALU_OP_ADD;
      end

      dec.alu_inv = (n0 == 4'h1) || (n0 == 4'h3) ||
                    (n0 == 4'hA && (n3 == 4'hE || n3[3:2] == 2'b01 || (n3[3] && n3[0])));
      dec.alu_cin = (n0 == 4'h1) ||
                    (n0 == 4'hA && (n3[3:2] == 2'b00 || (n3[3:2] == 2'b10 && !n3[0])));
      dec.cmp_op   = cmp_op_t'(n1[2:0]);
      dec.shift_op = shift_op_t'(n3[1:0]);
      return dec;
   endfunction

endpackage

// File: rtl/idli_dq_fifo_m.sv
// Encoding FIFO: DEPTH entries of 16b, head visible combinationally.
module idli_dq_fifo_m
   import idli_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [15:0]      push_data,
   input  logic             take,
   input  logic             flush,
   output logic [15:0]      head,
   output logic             vld,
   output logic [CNT_W-1:0] cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [15:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             push_ok;
   logic             take_ok;

   // Flush wins over both handshakes; full pushes and empty takes are dropped.
   assign push_ok = push && !flush && (cnt_reg != CNT_W'(DEPTH));
   assign take_ok = take && !flush && (cnt_reg != '0);

   // Storage write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (take_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         unique case ({push_ok, take_ok})
            2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
            2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

   assign head = mem[rd_ptr_reg];
   assign vld  = (cnt_reg != '0);
   assign cnt  = cnt_reg;

endmodule

// File: rtl/idli_decq_m.sv
// Instruction assembly queue: gathers LANE_W-bit beats into 16b encodings,
// queues them and presents the decoded head to execution.
module idli_decq_m
   import idli_pkg::*;
#(
   parameter int LANE_W = 4,
   parameter int DEPTH  = 2,
   parameter int BEATS  = 16 / LANE_W,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              i_dq_gck,
   input  logic              i_dq_rst,
   input  logic [LANE_W-1:0] i_dq_lane,
   input  logic              i_dq_lane_vld,
   output logic              o_dq_lane_rdy,
   input  logic              i_dq_flush,
   input  logic              i_dq_take,
   output logic              o_dq_vld,
   output logic [CNT_W-1:0]  o_dq_cnt,
   output logic [15:0]       o_dq_enc,
   output pipe_t             o_dq_pipe,
   output alu_op_t           o_dq_alu_op,
   output logic              o_dq_alu_inv,
   output logic              o_dq_alu_cin,
   output cmp_op_t           o_dq_cmp_op,
   output shift_op_t         o_dq_shift_op
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   logic [BEAT_W-1:0] beat_reg;
   logic [15:0]       asm_reg;
   logic [15:0]       word_next;
   logic              accept;
   logic              push;
   logic [15:0]       head;
   logic              fifo_vld;
   logic [CNT_W-1:0]  fifo_cnt;
   decode_t           dec;

   assign accept = i_dq_lane_vld && o_dq_lane_rdy;
   assign push   = accept && (beat_reg == LAST_BEAT);

   // Only the final beat needs FIFO space; earlier beats can always be taken.
   assign o_dq_lane_rdy = (fifo_cnt < CNT_W'(DEPTH)) || (beat_reg != LAST_BEAT);

   // Merge the incoming beat into its slot; beat 0 lands in the LSBs.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
         assign word_next[gi*LANE_W +: LANE_W] =
            (beat_reg == BEAT_W'(gi)) ? i_dq_lane : asm_reg[gi*LANE_W +: LANE_W];
      end
   endgenerate

   // Beat counter and partial word; a flush drops the beat seen that cycle.
   always_ff @(posedge i_dq_gck or posedge i_dq_rst) begin
      if (i_dq_rst) begin
         beat_reg <= '0;
         asm_reg  <= '0;
      end else if (i_dq_flush) begin
         beat_reg <= '0;
      end else if (accept) begin
         asm_reg  <= word_next;
         beat_reg <= push ? '0 : beat_reg + BEAT_W'(1);
      end
   end

   idli_dq_fifo_m #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (i_dq_gck),
      .rst       (i_dq_rst),
      .push      (push),
      .push_data (word_next),
      .take      (i_dq_take),
      .flush     (i_dq_flush),
      .head      (head),
      .vld       (fifo_vld),
      .cnt       (fifo_cnt)
   );

   // Empty queue presents a zero encoding, which decodes to a harmless ADD.
   assign o_dq_vld = fifo_vld;
   assign o_dq_cnt = fifo_cnt;
   assign o_dq_enc = fifo_vld ? head : 16'h0000;
   assign dec      = idli_decode_f(o_dq_enc);

   assign o_dq_pipe     = dec.pipe;
   assign o_dq_alu_op   = dec.alu_op;
   assign o_dq_alu_inv  = dec.alu_inv;
   assign o_dq_alu_cin  = dec.alu_cin;
   assign o_dq_cmp_op   = dec.cmp_op;
   assign o_dq_shift_op = dec.shift_op;

endmodule
